fifo_wr_arbiter: RTL

- Round-robin write arbiter that shares one FIFO write port between N_REQ requesters.
- Accepts words over per-requester valid/ready handshakes.
- Drives the FIFO write side (data_in, wr_en) from registered outputs.
- Throttles on the FIFO's full/almostfull flags so that a legal FIFO never overflows. Sits directly in front of the FIFO in the same clock domain.

---
 rtl/fifo_wr_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin write arbiter sharing one FIFO write port between N_REQ
//   requesters. A requester is granted for up to BURST_MAX accepted words,
//   then the grant moves on. The FIFO write side is driven from registers,
//   and issue is throttled on full/almostfull so that the FIFO never overflows.
//
// Parameters
//   FIFO_WIDTH  data word width (must match the FIFO)
//   N_REQ       number of requesters, 2..8
//   BURST_MAX   max words accepted per grant, 1..15
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   req_valid/ready   per-requester handshake
//   req_data          packed words, requester i at [i*FIFO_WIDTH +: FIFO_WIDTH]
//   fifo_full         FIFO full flag
//   fifo_almostfull   FIFO almostfull flag (one slot left)
//   fifo_overflow     FIFO overflow flag
//   fifo_wr_en        registered FIFO write enable
//   fifo_data_in      registered FIFO write data
//   gnt_valid/gnt_id  grant held / current owner
//   err_overflow      sticky overflow indication, cleared only by reset
//
// Optional feature (macro FIFO_WR_ARB_STATS_EN)
//   stat_words   saturating count of cycles with fifo_wr_en=1
//   stat_stalls  saturating count of GRANT cycles where the owner is valid
//                but the FIFO cannot take a word
module fifo_wr_arbiter #(
  parameter int FIFO_WIDTH = 16,
  parameter int N_REQ      = 4,
  parameter int BURST_MAX  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*FIFO_WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]              req_ready,
  input  logic                          fifo_full,
  input  logic                          fifo_almostfull,
  input  logic                          fifo_overflow,
  output logic                          fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]         fifo_data_in,
  output logic                          gnt_valid,
  output logic [$clog2(N_REQ)-1:0]      gnt_id,
`ifdef FIFO_WR_ARB_STATS_EN
  output logic [15:0]                   stat_words,
  output logic [15:0]                   stat_stalls,
`endif
  output logic                          err_overflow
);

  localparam int ID_W = $clog2(N_REQ);

  typedef enum logic [0:0] {IDLE, GRANT} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [ID_W-1:0] gnt_id_nxt;
  logic            gnt_valid_nxt;
  logic [3:0]      burst_cnt, burst_nxt, burst_inc;
  logic [ID_W-1:0] idx;
  logic            found;
  logic            can_issue;
  logic            accept;

  logic [FIFO_WIDTH-1:0] req_word [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign req_word[g] = req_data[g*FIFO_WIDTH +: FIFO_WIDTH];
  end

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // With almostfull set only one slot is left, so a write already in flight
  // must land before another word may be accepted.
  assign can_issue = !fifo_full && !(fifo_almostfull && fifo_wr_en);
  assign accept    = (state == GRANT) && req_valid[gnt_id] && can_issue;
  assign burst_inc = burst_cnt + 4'd1;

  always_comb begin
    req_ready = '0;
    if (state == GRANT && can_issue) req_ready[gnt_id] = 1'b1;
  end

  always_comb begin
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    gnt_id_nxt    = gnt_id;
    gnt_valid_nxt = gnt_valid;
    burst_nxt     = burst_cnt;
    idx           = '0;
    found         = 1'b0;
    case (state)
      IDLE: begin
        // First valid requester at or after rr_ptr, wrapping modulo N_REQ.
        for (int k = 0; k < N_REQ; k++) begin
          idx = ID_W'((int'(rr_ptr) + k) % N_REQ);
          if (!found && req_valid[idx]) begin
            found      = 1'b1;
            gnt_id_nxt = idx;
          end
        end
        if (found) begin
          state_nxt     = GRANT;
          gnt_valid_nxt = 1'b1;
          burst_nxt     = '0;
        end
      end
      GRANT: begin
        // A stall (owner valid, no issue slot) falls through and holds everything.
        if (!req_valid[gnt_id] || (can_issue && burst_inc == 4'(BURST_MAX))) begin
          state_nxt     = IDLE;
          gnt_valid_nxt = 1'b0;
          burst_nxt     = '0;
          rr_ptr_nxt    = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
        end else if (can_issue) begin
          burst_nxt = burst_inc;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage boundary: arbitration state and registered FIFO write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      gnt_id       <= '0;
      gnt_valid    <= 1'b0;
      burst_cnt    <= '0;
      fifo_wr_en   <= 1'b0;
      fifo_data_in <= '0;
      err_overflow <= 1'b0;
    end else begin
      state        <= state_nxt;
      rr_ptr       <= rr_ptr_nxt;
      gnt_id       <= gnt_id_nxt;
      gnt_valid    <= gnt_valid_nxt;
      burst_cnt    <= burst_nxt;
      fifo_wr_en   <= accept;
      if (accept) fifo_data_in <= req_word[gnt_id];
      if (fifo_overflow) err_overflow <= 1'b1;
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic stall;
  assign stall = (state == GRANT) && req_valid[gnt_id] && !can_issue;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_words  <= '0;
      stat_stalls <= '0;
    end else begin
      if (fifo_wr_en) stat_words  <= sat_inc16(stat_words);
      if (stall)      stat_stalls <= sat_inc16(stat_stalls);
    end
  end
`endif

endmodule
